// File: rtl/single_port_ram.sv
// Single-port synchronous RAM with a registered read port.
// One access per cycle on a shared address: a write wins over a read on the
// same edge and leaves data_out untouched. An active-high asynchronous reset
// clears every word and the output register immediately.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  wr_fire_s;
  logic                  rd_fire_s;

  // Decode the access for this edge: a write always takes the port, a read only when no write
  always_comb begin
    wr_fire_s = 1'b0;
    rd_fire_s = 1'b0;
    if (wr_en) begin
      wr_fire_s = 1'b1;
      rd_fire_s = 1'b0;
    end else begin
      wr_fire_s = 1'b0;
      rd_fire_s = rd_en;
    end
  end

  // Storage array: cleared at once by reset, full-word write otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r <= '{default: {DATA_WIDTH{1'b0}}};
    end else if (wr_fire_s) begin
      mem_r[address] <= data_in;
    end
  end

  // Read register: loads only on a read-only cycle, otherwise holds its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_fire_s) begin
      data_out_r <= mem_r[address];
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: directed scenarios plus random
// traffic, checked every cycle against a behavioural model of the memory.
`timescale 1ns/1ps
module tb_single_port_ram;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = 8'h00;
  logic [AW-1:0] address = 2'd0;
  logic [DW-1:0] data_out;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: sparse memory where absent entries read as zero
  logic [DW-1:0] mem_m [int];
  logic [DW-1:0] dout_m = 8'h00;

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .address  (address),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] peek(int a);
    if (mem_m.exists(a)) return mem_m[a];
    return 8'h00;
  endfunction

  // Model update: reset wipes everything; otherwise write wins, read loads output
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_m.delete();
      dout_m = 8'h00;
    end else if (wr_en) begin
      mem_m[int'(address)] = data_in;
    end else if (rd_en) begin
      dout_m = peek(int'(address));
    end
  end

  // Per-cycle compare of DUT output against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if (data_out !== dout_m) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: data_out=%h model=%h", $time, data_out, dout_m);
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access: drive between edges, let one rising edge sample it, then wiggle inputs
  task automatic op(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wiggle();
    #1;
    address = AW'($urandom_range(0, 3));
    data_in = DW'($urandom_range(0, 255));
  endtask

  logic [AW-1:0] ra;
  logic [DW-1:0] rd_v;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_dout", data_out, 8'h00);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // Never-written location reads zero
    op(1'b0, 1'b1, 2'd3, 8'h00);
    check("unwritten_a3", data_out, 8'h00);

    // Write 0xAA to 2, then read it back
    op(1'b1, 1'b0, 2'd2, 8'hAA);
    check("wr_a2_hold", data_out, 8'h00);
    op(1'b0, 1'b1, 2'd2, 8'h00);
    check("rd_a2", data_out, 8'hAA);
    check("model_rd_a2", dout_m, 8'hAA);

    // Two writes then two reads
    op(1'b1, 1'b0, 2'd0, 8'hF0);
    op(1'b1, 1'b0, 2'd1, 8'hA4);
    op(1'b0, 1'b1, 2'd0, 8'h00);
    check("rd_a0", data_out, 8'hF0);
    op(1'b0, 1'b1, 2'd1, 8'h00);
    check("rd_a1", data_out, 8'hA4);

    // Overwrite address 1; output must not move during the write
    op(1'b1, 1'b0, 2'd1, 8'hC2);
    check("overwrite_hold", data_out, 8'hA4);
    op(1'b0, 1'b1, 2'd1, 8'h00);
    check("rd_a1_over", data_out, 8'hC2);

    // Simultaneous write and read: write wins, no read-through
    op(1'b1, 1'b1, 2'd1, 8'h55);
    check("wr_rd_hold", data_out, 8'hC2);
    check("model_wr_rd_hold", dout_m, 8'hC2);
    op(1'b0, 1'b0, 2'd1, 8'h00);
    check("idle_hold", data_out, 8'hC2);
    op(1'b0, 1'b1, 2'd1, 8'h00);
    check("rd_a1_55", data_out, 8'h55);

    // Random traffic with inputs changing between edges
    for (int i = 0; i < 400; i++) begin
      op(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
         AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) wiggle();
    end

    // Known contents, a read, then async reset between edges with a write pending
    op(1'b1, 1'b0, 2'd3, 8'h3C);
    op(1'b0, 1'b1, 2'd3, 8'h00);
    check("pre_reset_rd", data_out, 8'h3C);
    @(negedge clk);
    #2;
    wr_en = 1'b1; rd_en = 1'b1; address = 2'd0; data_in = 8'h99;
    rst = 1'b1;
    #1;
    check("async_reset_dout", data_out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_ignores_ops", data_out, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ra = AW'(a);
      op(1'b0, 1'b1, ra, 8'hFF);
      check($sformatf("post_reset_a%0d", a), data_out, 8'h00);
    end

    // Normal operation resumes after reset
    op(1'b1, 1'b0, 2'd2, 8'h81);
    op(1'b0, 1'b1, 2'd2, 8'h00);
    rd_v = data_out;
    check("post_reset_wr_rd", rd_v, 8'h81);

    op(1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/single_port_ram.md
SINGLE_PORT_RAM -- requirements
Module: single_port_ram

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 2, giving the address width; depth = 2**ADDR_WIDTH (4 words at default).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port wr_en, input, 1 bit: write enable.
REQ-006 The module SHALL have port rd_en, input, 1 bit: read enable.
REQ-007 The module SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-008 The module SHALL have port address, input, ADDR_WIDTH bits: shared read/write address.
REQ-009 The module SHALL have port data_out, output, DATA_WIDTH bits: registered read data.

Function
REQ-010 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, single port, one access per cycle.
REQ-011 On a rising clk edge with wr_en=1, mem[address] SHALL take data_in; the new value SHALL be readable from the next cycle onward.
REQ-012 On a rising clk edge with wr_en=0 and rd_en=1, data_out SHALL take mem[address]; read latency is 1 clock, with data_out valid after that edge.
REQ-013 When wr_en=1 and rd_en=1 on the same edge, the write SHALL take priority, and data_out SHALL hold its previous value (no read-through).
REQ-014 When wr_en=0 and rd_en=0, memory and data_out SHALL hold their values (idle).
REQ-015 data_out SHALL hold its last read value across any number of non-read cycles.
REQ-016 A write SHALL overwrite the full word; partial or byte writes are not supported.
REQ-017 Every address value 0..2**ADDR_WIDTH-1 SHALL be valid; there is no out-of-range case and no wrap logic.
REQ-018 A read of a location not written since reset SHALL return all zeros.
REQ-019 Back-to-back accesses SHALL be supported every cycle with no stall or handshake.
REQ-020 Inputs SHALL be sampled only at the rising edge; changes between edges SHALL have no effect.

Reset
REQ-021 While rst=1, all memory words and data_out SHALL be forced to 0 immediately, independent of clk.
REQ-022 While rst=1, writes and reads SHALL be ignored.
REQ-023 A reset asserted mid-operation SHALL discard any write in progress in that cycle, and all locations SHALL read 0 afterwards.
REQ-024 The first rising edge after rst deasserts SHALL perform normal operation according to wr_en and rd_en.

Verification
REQ-025 The bench SHALL cover reset, then a write of 0xAA to address 2, then a read of address 2 -> data_out = 0xAA one cycle after the read edge.
REQ-026 The bench SHALL cover writes of 0xF0 to address 0 and 0xA4 to address 1, then reads of address 0 then address 1 -> data_out = 0xF0, then 0xA4.
REQ-027 The bench SHALL cover an overwrite of address 1 with 0xC2 (rd_en=0), then a read of address 1 -> data_out = 0xC2, and data_out unchanged during the write cycle.
REQ-028 The bench SHALL cover a read of never-written address 3 after reset -> data_out = 0x00.
REQ-029 The bench SHALL cover wr_en=1 and rd_en=1 with address 1 and data_in 0x55 -> mem[1] = 0x55, data_out keeps its prior value, and the next read of address 1 gives 0x55.
REQ-030 The bench SHALL cover rst asserted asynchronously between edges after data has been written -> data_out = 0 at once, and reads of all 4 addresses return 0x00.
